pipelined_addsub: RTL and testbench
===================================

Name: pipelined_addsub

Overview:
Parametrised, pipelined ripple-carry adder/subtractor. It is the next generation of the team's fixed 8-bit adder: generic width, carry-in, subtract mode, signed overflow flag, and a valid/ready stream interface.
- The carry chain is cut into STAGES equal slices, one register stage per slice. Operands are skewed in and results are deskewed out.
- Throughput is one operation per cycle at a fixed latency.
- Used by datapath blocks that need wide adds at high clock rates.

Parameters:
- WIDTH, 32, operand/result width in bits; must be >= 1.
- STAGES, 4, number of pipeline stages (= carry-chain slices); 1 <= STAGES <= WIDTH, WIDTH % STAGES == 0 (elaboration error otherwise).
- Derived: SLICE = WIDTH/STAGES, bits per slice.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  input operation valid.
- in_ready  out  1  block can accept an input this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- sub  in  1  0: add, 1: subtract.
- c_in  in  1  carry-in (add) / borrow-in (subtract).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  result.
- c_out  out  1  carry-out of MSB (subtract: 1 = no borrow).
- ovf  out  1  signed (two's complement) overflow.

Behaviour:
- Arithmetic:
  - add: {c_out,sum} = a + b + c_in.
  - sub: {c_out,sum} = a + ~b + ~c_in, i.e. a - b - c_in, with c_out = NOT borrow.
  - Slice-0 carry-in = c_in XOR sub; b inverted when sub=1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Results are modulo 2^WIDTH; wrap-around is normal, not an error.
- Pipeline:
  - Stage k (0..STAGES-1) adds slice k of its registered operands plus the registered carry from stage k-1.
  - Upper operand slices travel with their operation until consumed.
  - Completed lower sum slices are carried forward to the output.
  - sub is pre-applied at entry: b inverted, carry set.
- Latency: an operation accepted at edge N appears on out_valid/sum/c_out/ovf after edge N+STAGES, provided there is no stall.
- Handshake:
  - Global pipeline enable en = out_ready | ~out_valid.
  - in_ready = en (combinational).
  - Input is accepted when in_valid & in_ready.
  - When en=0, every stage holds; outputs stay stable while out_valid=1 and out_ready=0.
  - A stage valid bit shifts in (in_valid & in_ready) when en=1. Bubbles propagate; they are not collapsed.
  - Result transfer occurs when out_valid & out_ready.
  - in_valid with in_ready=0: the input is not captured; the source must hold it.
- Throughput: 1 op/cycle with out_ready held high; back-to-back ops never mix carries.
- Reset (synchronous, active-high, takes priority over en):
  - All stage valid bits clear.
  - out_valid=0, sum=0, c_out=0, ovf=0, in_ready=1 on the cycle after rst deasserts.
  - Reset mid-operation discards all in-flight ops; none emerge later.
- STAGES=1: one register stage, latency 1, full-width ripple.
- STAGES=WIDTH: 1-bit slices, latency WIDTH.
- Outputs are registered; only in_ready is combinational from out_ready/out_valid.

Decomposition:
- Shared package: function for the slice-0 carry (c_in ^ sub); elaboration-time check helper for the WIDTH/STAGES divisibility rule.
- One sub-module: addsub_slice — combinational SLICE-bit ripple chain of full adders (inputs a, b, cin; outputs s, cout, and carry into its MSB for ovf). STAGES instances are generated; the top module holds the skew/deskew registers and handshake.

Test Plan:
- WIDTH=8, STAGES=4, out_ready=1: a=0xFF, b=0x01, sub=0, c_in=0 -> 4 cycles later sum=0x00, c_out=1, ovf=0.
- a=0x7F, b=0x01, add -> sum=0x80, c_out=0, ovf=1; a=0x05, b=0x07, sub=1, c_in=0 -> sum=0xFE, c_out=0, ovf=0; a=0x80, b=0x01, sub=1 -> sum=0x7F, ovf=1.
- Stream 16 back-to-back random ops (mixed add/sub, c_in random), out_ready=1 -> results in order, one per cycle, matching the reference model, after first-result latency 4.
- Same stream with out_ready random 50% -> in_ready tracks en; no result dropped, duplicated or changed while stalled; order preserved.
- 3 ops in flight, assert rst 1 cycle -> out_valid stays 0 for the following 5 cycles; the next op sent emerges alone with correct value.
- Re-run the first two scenarios at STAGES=1 (latency 1) and STAGES=8 (latency 8), plus WIDTH=32/STAGES=4: 0xFFFFFFFF+0+c_in=1 -> sum=0, c_out=1.

Source files
------------

// File: rtl/pipelined_addsub_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub_pkg
// Purpose  : Shared helpers for the pipelined adder/subtractor.
// Revision : 1.0  initial release
// ============================================================================
package pipelined_addsub_pkg;

    // Subtract is a + ~b + 1, so the borrow-in flips the entry carry.
    function automatic logic slice0_carry(input logic c_in, input logic sub);
        return c_in ^ sub;
    endfunction

    function automatic bit stages_legal(input int width, input int stages);
        return (width >= 1) && (stages >= 1) && (stages <= width) &&
               ((width % stages) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/addsub_slice.sv
`default_nettype none
// ============================================================================
// Module   : addsub_slice
// Purpose  : Combinational SLICE-bit ripple-carry chain of full adders.
// Revision : 1.0  initial release
// ============================================================================
module addsub_slice
    import pipelined_addsub_pkg::*;
#(
    parameter int SLICE = 8
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [SLICE:0] w_c;

    assign w_c[0] = cin;

    for (genvar i = 0; i < SLICE; i++) begin : g_bit
        assign s[i]       = a[i] ^ b[i] ^ w_c[i];
        assign w_c[i + 1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end

    assign cout = w_c[SLICE];
    assign cmsb = w_c[SLICE-1];

endmodule
`default_nettype wire

// File: rtl/pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : pipelined_addsub
// Purpose  : Pipelined ripple-carry adder/subtractor, one slice per stage,
//            with a valid/ready stream interface and a global stall.
// Revision : 1.0  initial release
// ============================================================================
module pipelined_addsub
    import pipelined_addsub_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             c_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    localparam int c_slice = WIDTH / STAGES;

    if (!stages_legal(WIDTH, STAGES)) begin : g_param_check
        $error("pipelined_addsub: STAGES must be in 1..WIDTH and divide WIDTH");
    end

    logic             w_en;
    logic             w_fin_v;
    logic [WIDTH-1:0] w_fin_sum;
    logic             w_fin_cout;
    logic             w_fin_ovf;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;
    logic             r_ovf;

    assign w_en     = out_ready | ~r_out_valid;
    assign in_ready = w_en;

    // r_acc holds finished sum slices below slice k and untouched A above it;
    // r_b keeps only the B slices not yet consumed, so it narrows per stage.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int c_rem = WIDTH - k * c_slice;

        logic               r_v;
        logic               r_c;
        logic [WIDTH-1:0]   r_acc;
        logic [c_rem-1:0]   r_b;
        logic [c_slice-1:0] w_s;
        logic               w_cout;
        logic               w_cmsb;
        logic [WIDTH-1:0]   w_acc_next;

        addsub_slice #(
            .SLICE (c_slice)
        ) u_slice (
            .a    (r_acc[k*c_slice +: c_slice]),
            .b    (r_b[c_slice-1:0]),
            .cin  (r_c),
            .s    (w_s),
            .cout (w_cout),
            .cmsb (w_cmsb)
        );

        always_comb begin
            w_acc_next                       = r_acc;
            w_acc_next[k*c_slice +: c_slice] = w_s;
        end

        if (k == 0) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (w_en) begin
                    r_v   <= in_valid;
                    r_acc <= a;
                    r_b   <= sub ? ~b : b;
                    r_c   <= slice0_carry(c_in, sub);
                end
            end
        end else begin : g_next
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_v <= 1'b0;
                end else if (w_en) begin
                    r_v   <= g_stage[k-1].r_v;
                    r_acc <= g_stage[k-1].w_acc_next;
                    r_b   <= g_stage[k-1].r_b[WIDTH-(k-1)*c_slice-1:c_slice];
                    r_c   <= g_stage[k-1].w_cout;
                end
            end
        end

        if (k == STAGES - 1) begin : g_last
            assign w_fin_v    = r_v;
            assign w_fin_sum  = w_acc_next;
            assign w_fin_cout = w_cout;
            assign w_fin_ovf  = w_cout ^ w_cmsb;
        end else begin : g_mid
            // Only the top slice feeds the overflow flag.
            logic w_unused;
            assign w_unused = w_cmsb;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_sum       <= '0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
        end else if (w_en) begin
            r_out_valid <= w_fin_v;
            if (w_fin_v) begin
                r_sum  <= w_fin_sum;
                r_cout <= w_fin_cout;
                r_ovf  <= w_fin_ovf;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign c_out     = r_cout;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_pipelined_addsub.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipelined_addsub
// Purpose  : Scoreboard bench driving four configurations of pipelined_addsub
//            (8/4, 8/1, 8/8, 32/4) from one shared stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipelined_addsub;

    localparam int NCFG = 4;

    function automatic int cfg_w(input int i);
        return (i == 3) ? 32 : 8;
    endfunction

    function automatic int cfg_s(input int i);
        case (i)
            0:       return 4;
            1:       return 1;
            2:       return 8;
            default: return 4;
        endcase
    endfunction

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        int          due;
    } exp_t;

    logic        clk       = 1'b0;
    logic        rst       = 1'b1;
    logic        in_valid  = 1'b0;
    logic        sub       = 1'b0;
    logic        c_in      = 1'b0;
    logic        out_ready = 1'b1;
    logic [31:0] a         = '0;
    logic [31:0] b         = '0;

    logic [NCFG-1:0] in_ready_v;
    logic [NCFG-1:0] out_valid_v;
    logic [NCFG-1:0] cout_v;
    logic [NCFG-1:0] ovf_v;
    logic [31:0]     sum_v [NCFG];

    exp_t q [NCFG][$];

    int cyc          = 0;
    int n_vec        = 0;
    int n_bad        = 0;
    int n_expired    = 0;
    int seen_expired = 0;
    bit strict       = 1'b0;
    bit rand_rdy     = 1'b0;
    bit chk_idle     = 1'b0;
    bit chk_rst      = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < NCFG; i++) begin : g_dut
        localparam int W = cfg_w(i);
        logic [W-1:0] w_sum;

        pipelined_addsub #(
            .WIDTH  (W),
            .STAGES (cfg_s(i))
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready_v[i]),
            .a         (a[W-1:0]),
            .b         (b[W-1:0]),
            .sub       (sub),
            .c_in      (c_in),
            .out_valid (out_valid_v[i]),
            .out_ready (out_ready),
            .sum       (w_sum),
            .c_out     (cout_v[i]),
            .ovf       (ovf_v[i])
        );

        assign sum_v[i] = 32'(w_sum);
    end

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic exp_t model(input int w, input logic [31:0] ta,
                                   input logic [31:0] tb_, input logic ts,
                                   input logic tc);
        exp_t   e;
        longint m, ua, ub, sa, sb, ci, ur, sr;
        m  = longint'(1) << w;
        ua = longint'(ta) & (m - 1);
        ub = longint'(tb_) & (m - 1);
        sa = (ua >= m / 2) ? ua - m : ua;
        sb = (ub >= m / 2) ? ub - m : ub;
        ci = longint'(tc);
        ur = ts ? (ua - ub - ci) : (ua + ub + ci);
        sr = ts ? (sa - sb - ci) : (sa + sb + ci);
        e.sum  = 32'(ur & (m - 1));
        e.cout = ts ? (ua >= ub + ci) : (ur >= m);
        e.ovf  = (sr >= m / 2) || (sr < -(m / 2));
        e.due  = 0;
        return e;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [31:0] ta, input logic [31:0] tb_,
                        input logic ts, input logic tc);
        int   wait_n;
        bit   done;
        exp_t e;
        wait_n   = 0;
        a        = ta;
        b        = tb_;
        sub      = ts;
        c_in     = tc;
        in_valid = 1'b1;
        forever begin
            #2;
            for (int i = 0; i < NCFG; i++) begin
                if (in_ready_v[i]) begin
                    e     = model(cfg_w(i), ta, tb_, ts, tc);
                    e.due = cyc + 1 + cfg_s(i);
                    q[i].push_back(e);
                end
            end
            done = in_ready_v[0];
            @(posedge clk);
            #1;
            if (done) break;
            wait_n++;
            if (wait_n > 200) begin
                n_expired++;
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((q[0].size() + q[1].size() + q[2].size() + q[3].size()) != 0 && t < 300) begin
            @(posedge clk);
            #1;
            t++;
        end
        if (t >= 300) n_expired++;
        idle(2);
    endtask

    task automatic send_rand();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: compares whatever each DUT presents against its queue front.
    always @(negedge clk) begin
        exp_t e;
        if (n_expired != seen_expired) begin
            n_vec++;
            n_bad++;
            $display("FAIL timeout: got %0d expired waits, required 0", n_expired);
            seen_expired = n_expired;
        end
        if (chk_rst) begin
            for (int i = 0; i < NCFG; i++) begin
                n_vec++;
                if ({out_valid_v[i], cout_v[i], ovf_v[i], in_ready_v[i], sum_v[i]} !== {4'b0001, 32'h0}) begin
                    n_bad++;
                    $display("FAIL cfg%0d reset_state: got valid=%b sum=%h c_out=%b ovf=%b in_ready=%b, required 0/0/0/0/1",
                             i, out_valid_v[i], sum_v[i], cout_v[i], ovf_v[i], in_ready_v[i]);
                end
            end
        end
        if (chk_idle) begin
            for (int i = 0; i < NCFG; i++) begin
                n_vec++;
                if (out_valid_v[i] !== 1'b0) begin
                    n_bad++;
                    $display("FAIL cfg%0d post_reset_quiet: got out_valid=%b, required 0", i, out_valid_v[i]);
                end
            end
        end
        if (!rst && !chk_rst) begin
            for (int i = 0; i < NCFG; i++) begin
                if (out_valid_v[i] === 1'b1) begin
                    n_vec++;
                    if (q[i].size() == 0) begin
                        n_bad++;
                        $display("FAIL cfg%0d unexpected_result: got sum=%h, required no output", i, sum_v[i]);
                    end else begin
                        e = q[i][0];
                        if ({cout_v[i], ovf_v[i], sum_v[i]} !== {e.cout, e.ovf, e.sum}) begin
                            n_bad++;
                            $display("FAIL cfg%0d result: got sum=%h c_out=%b ovf=%b, required sum=%h c_out=%b ovf=%b",
                                     i, sum_v[i], cout_v[i], ovf_v[i], e.sum, e.cout, e.ovf);
                        end else if (strict && cyc != e.due) begin
                            n_bad++;
                            $display("FAIL cfg%0d latency: got cycle %0d, required cycle %0d", i, cyc, e.due);
                        end
                        if (out_ready) void'(q[i].pop_front());
                    end
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got no finish by time limit, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle(3);
        rst     = 1'b0;
        chk_rst = 1'b1;
        idle(1);
        chk_rst = 1'b0;

        // Directed corner cases with out_ready held high.
        strict = 1'b1;
        send(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_007F, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b0);
        send(32'h0000_0080, 32'h0000_0001, 1'b1, 1'b0);
        send(32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b1);
        send(32'h0000_0000, 32'h0000_0000, 1'b1, 1'b1);
        send(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0);
        drain();

        // Back-to-back random stream, then with gaps.
        repeat (16) send_rand();
        drain();
        repeat (8) begin
            send_rand();
            idle(int'($urandom_range(0, 2)));
        end
        drain();

        // Random backpressure.
        strict   = 1'b0;
        rand_rdy = 1'b1;
        repeat (40) send_rand();
        drain();
        rand_rdy = 1'b0;
        idle(2);

        // Reset with operations in flight.
        strict = 1'b1;
        repeat (3) send_rand();
        rst = 1'b1;
        for (int i = 0; i < NCFG; i++) q[i].delete();
        idle(1);
        rst     = 1'b0;
        chk_rst = 1'b1;
        idle(1);
        chk_rst  = 1'b0;
        chk_idle = 1'b1;
        idle(5);
        chk_idle = 1'b0;
        send(32'h1234_5678, 32'h0F0F_0F0F, 1'b1, 1'b1);
        drain();

        idle(3);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
